axi_err_slv_multi: RTL and testbench
====================================

AXI_ERR_SLV_MULTI -- requirements
Module: axi_err_slv_multi

Interface
REQ-001 SHALL have parameter IdWidth, default 4, meaning the AXI ID width.
REQ-002 SHALL have parameter AddrWidth, default 32, meaning the AXI address width.
REQ-003 SHALL have parameter DataWidth, default 64, meaning the R data width.
REQ-004 SHALL have parameter Resp, default 2'b11 (DECERR), meaning the B/R response code.
REQ-005 SHALL have parameter RespData, default 64'hca11ab1ebadcab1e, meaning the R data pattern, zero-extended or truncated to DataWidth.
REQ-006 SHALL have parameter MaxTrans, default 4, meaning the depth of the AW and AR queues (range 1..16).
REQ-007 SHALL have ports clk_i (in, 1, clock) and rst_i (in, 1, reset). One clock; reset is synchronous and active-high.
REQ-008 SHALL have AW ports: aw_valid_i 1, aw_ready_o 1, aw_id_i IdWidth, aw_addr_i AddrWidth, aw_len_i 8.
REQ-009 SHALL have W ports: w_valid_i 1, w_ready_o 1, w_last_i 1. B ports: b_valid_o 1, b_ready_i 1, b_id_o IdWidth, b_resp_o 2.
REQ-010 SHALL have AR ports: ar_valid_i 1, ar_ready_o 1, ar_id_i IdWidth, ar_addr_i AddrWidth, ar_len_i 8.
REQ-011 SHALL have R ports: r_valid_o 1, r_ready_i 1, r_id_o IdWidth, r_data_o DataWidth, r_resp_o 2, r_last_o 1.
REQ-012 SHALL have log ports: log_clr_i in 1, err_cnt_o out 16, err_addr_o out AddrWidth, err_id_o out IdWidth, err_is_wr_o out 1, err_valid_o out 1, len_mismatch_o out 1.

Function
REQ-013 aw_ready_o SHALL equal "AW queue not full". The AW queue stores {id, len}. Push on aw_valid_i & aw_ready_o.
REQ-014 w_ready_o SHALL be 1 only when the AW queue is non-empty and the B queue (depth 2) is not full.
REQ-015 W beat handshakes SHALL increment a beat counter. When a beat with w_last_i=1 is accepted: pop AW, push its id to B, clear the counter.
REQ-016 When w_last_i is accepted and the beat count != len+1, len_mismatch_o SHALL pulse high for 1 cycle. Data SHALL be sunk regardless.
REQ-017 b_valid_o SHALL equal "B queue non-empty". b_id_o SHALL be the head id and b_resp_o SHALL equal Resp. Pop on b_valid_o & b_ready_i.
REQ-018 ar_ready_o SHALL equal "AR queue not full". The AR queue stores {id, len}.
REQ-019 The R FSM SHALL have states IDLE and BURST.
  - IDLE -> BURST when the AR queue is non-empty, loading the beat counter with len.
  - BURST drives r_valid_o=1, r_id_o = head id, r_data_o = RespData, r_resp_o = Resp, r_last_o = (counter==0).
REQ-020 In BURST, each r_ready_i handshake SHALL decrement the counter. The handshake at counter==0 SHALL pop AR and return to IDLE.
REQ-021 Latency: an AR accepted at cycle n SHALL give the first r_valid_o at n+2 when the R FSM is idle. Consecutive bursts SHALL have exactly 1 idle cycle between them.
REQ-022 r_valid_o SHALL stay asserted and all R outputs SHALL stay stable while r_ready_i=0. The same applies to B.
REQ-023 Reads and writes SHALL proceed independently. Simultaneous push and pop on a full queue SHALL NOT be allowed: ready follows "not full" only.
REQ-024 len=0 SHALL give a single beat with r_last_o=1. len=255 SHALL give 256 beats with no counter wrap.

Reset
REQ-025 rst_i SHALL clear all queues and counters and set the FSM to IDLE.
REQ-026 The first cycle after reset SHALL have aw_ready_o=ar_ready_o=1 and all other outputs 0.
REQ-027 Reset mid-burst SHALL abort the burst and drop all queued transactions without emitting further beats.

Configuration
REQ-028 With AXI_ERR_SLV_LOG_EN defined:
  - err_cnt_o SHALL count accepted AW+AR handshakes and saturate at 16'hFFFF. Simultaneous AW and AR SHALL add 2.
  - On the first handshake with err_valid_o=0, the log SHALL capture addr, id and err_is_wr_o (AW wins ties) and set err_valid_o.
  - log_clr_i SHALL clear the log. A handshake in the same cycle as log_clr_i SHALL be captured after the clear, i.e. counted 1 and logged.
REQ-029 Without AXI_ERR_SLV_LOG_EN, all log outputs SHALL be constant 0, log_clr_i SHALL be ignored, and no log registers SHALL exist. len_mismatch_o is unaffected by the macro.

Structure
REQ-030 Package axi_err_pkg SHALL hold the RESP_OKAY/EXOKAY/SLVERR/DECERR constants, LenWidth=8 and ErrCntWidth=16.
REQ-031 A single sub-module axi_err_fifo (sync, non-fall-through, parametrised width/depth, full/empty) SHALL be instantiated for AW, B and AR.

Verification
REQ-032 AR id=3 len=3, r_ready_i=1 -> 4 R beats with id 3, data RespData, resp 2'b11, r_last_o only on beat 4, first beat at n+2.
REQ-033 AW id=5 len=1, 2 W beats with last on beat 2 -> one B with id 5, resp 2'b11. With last on beat 1 -> len_mismatch_o pulses once.
REQ-034 MaxTrans=2: 3 ARs back-to-back with r_ready_i=0 -> ar_ready_o=0 after 2 accepted, reasserts after the first burst completes.
REQ-035 r_ready_i toggling 1/0 mid-burst -> R outputs stable while stalled, beat count and order unchanged.
REQ-036 LOG_EN: AW addr 0x1000 and AR addr 0x2000 in the same cycle -> err_cnt_o=2, err_addr_o=0x1000, err_is_wr_o=1. log_clr_i -> all log outputs 0.
REQ-037 rst_i asserted during beat 2 of a len=7 read -> r_valid_o=0 next cycle, queues empty, no further beats.

Source files
------------

// File: rtl/axi_err_pkg.sv
// Shared constants and types for the AXI error slave.
//   RESP_*      : AXI response encodings
//   LenWidth    : AXI burst length field width
//   ErrCntWidth : width of the error-log handshake counter
//   r_state_e   : read-channel FSM state
package axi_err_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned LenWidth    = 8;
  localparam int unsigned ErrCntWidth = 16;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

endpackage

// File: rtl/axi_err_fifo.sv
// Synchronous, non-fall-through FIFO.
// Data written at a clock edge becomes visible on rdata_o from the next cycle on.
// Pushing when full and popping when empty are ignored.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write side
//   pop_i, rdata_o    : read side (rdata_o is the head entry)
//   full_o, empty_o   : occupancy flags
module axi_err_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  // A depth-1 FIFO still needs a 1-bit pointer; it simply never leaves 0.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = ptr_inc(wptr_q);
    if (pop_ok)  rptr_d = ptr_inc(rptr_q);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_err_slv_multi.sv
// AXI error slave with outstanding-transaction queues.
// Every write and read is answered with response Resp; read data is RespData.
// Write data is sunk; a burst whose W beat count disagrees with AW len
// raises a one-cycle len_mismatch_o pulse.
// Optional error log, enabled by defining AXI_ERR_SLV_LOG_EN.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   aw_* / w_* / b_*             : write address, write data, write response
//   ar_* / r_*                   : read address, read data
//   log_clr_i                    : clear the error log
//   err_cnt_o                    : saturating count of accepted AW+AR handshakes
//   err_addr_o/err_id_o/err_is_wr_o/err_valid_o : first logged transaction
//   len_mismatch_o               : W beat count != AW len+1 (one-cycle pulse)
module axi_err_slv_multi
  import axi_err_pkg::*;
#(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter logic [1:0]  Resp      = RESP_DECERR,
  parameter logic [63:0] RespData  = 64'hca11ab1ebadcab1e,
  parameter int unsigned MaxTrans  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // AW
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [LenWidth-1:0]    aw_len_i,
  // W
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic                   w_last_i,
  // B
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  // AR
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [LenWidth-1:0]    ar_len_i,
  // R
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  // log
  input  logic                   log_clr_i,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic [AddrWidth-1:0]   err_addr_o,
  output logic [IdWidth-1:0]     err_id_o,
  output logic                   err_is_wr_o,
  output logic                   err_valid_o,
  output logic                   len_mismatch_o
);

  localparam int unsigned QW = IdWidth + LenWidth;
  localparam logic [DataWidth-1:0] RData = DataWidth'(RespData);

  // ---------------------------------------------------------------- write path
  logic               aw_full, aw_empty, aw_hs;
  logic [QW-1:0]      aw_head;
  logic [IdWidth-1:0] aw_head_id;
  logic [LenWidth-1:0] aw_head_len;
  logic               b_full, b_empty, b_pop;
  logic [IdWidth-1:0] b_head;
  logic               w_hs, w_last_hs;
  // One bit wider than len so 256-beat bursts fit; saturates so an
  // over-long burst can never wrap back onto a matching count.
  logic [LenWidth:0]  wcnt_q, wcnt_d;
  logic               len_mismatch_q, len_mismatch_d;

  assign aw_ready_o = ~aw_full;
  assign aw_hs      = aw_valid_i & aw_ready_o;
  assign {aw_head_id, aw_head_len} = aw_head;

  assign w_ready_o  = ~aw_empty & ~b_full;
  assign w_hs       = w_valid_i & w_ready_o;
  assign w_last_hs  = w_hs & w_last_i;

  axi_err_fifo #(.Width(QW), .Depth(MaxTrans)) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_hs),
    .wdata_i ({aw_id_i, aw_len_i}),
    .pop_i   (w_last_hs),
    .rdata_o (aw_head),
    .full_o  (aw_full),
    .empty_o (aw_empty)
  );

  axi_err_fifo #(.Width(IdWidth), .Depth(2)) u_b_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_last_hs),
    .wdata_i (aw_head_id),
    .pop_i   (b_pop),
    .rdata_o (b_head),
    .full_o  (b_full),
    .empty_o (b_empty)
  );

  // wcnt_q counts beats already taken, so the burst is well-formed
  // exactly when the last beat arrives with wcnt_q == len.
  always_comb begin
    wcnt_d         = wcnt_q;
    len_mismatch_d = 1'b0;
    if (w_last_hs) begin
      wcnt_d         = '0;
      len_mismatch_d = (wcnt_q != {1'b0, aw_head_len});
    end else if (w_hs && (wcnt_q != '1)) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt_q         <= '0;
      len_mismatch_q <= 1'b0;
    end else begin
      wcnt_q         <= wcnt_d;
      len_mismatch_q <= len_mismatch_d;
    end
  end

  assign len_mismatch_o = len_mismatch_q;

  assign b_valid_o = ~b_empty;
  assign b_pop     = b_valid_o & b_ready_i;
  assign b_id_o    = b_valid_o ? b_head : '0;
  assign b_resp_o  = b_valid_o ? Resp : 2'b00;

  // ----------------------------------------------------------------- read path
  logic                ar_full, ar_empty, ar_hs, ar_pop;
  logic [QW-1:0]       ar_head;
  logic [IdWidth-1:0]  ar_head_id;
  logic [LenWidth-1:0] ar_head_len;
  r_state_e            r_state_q, r_state_d;
  logic [LenWidth-1:0] rcnt_q, rcnt_d;

  assign ar_ready_o = ~ar_full;
  assign ar_hs      = ar_valid_i & ar_ready_o;
  assign {ar_head_id, ar_head_len} = ar_head;

  axi_err_fifo #(.Width(QW), .Depth(MaxTrans)) u_ar_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ar_hs),
    .wdata_i ({ar_id_i, ar_len_i}),
    .pop_i   (ar_pop),
    .rdata_o (ar_head),
    .full_o  (ar_full),
    .empty_o (ar_empty)
  );

  // The head stays in the AR queue for the whole burst and is popped on
  // the last beat; the IDLE cycle this forces between bursts is intended.
  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    ar_pop    = 1'b0;
    r_valid_o = 1'b0;
    r_id_o    = '0;
    r_data_o  = '0;
    r_resp_o  = 2'b00;
    r_last_o  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (!ar_empty) begin
          r_state_d = R_BURST;
          rcnt_d    = ar_head_len;
        end
      end
      R_BURST: begin
        r_valid_o = 1'b1;
        r_id_o    = ar_head_id;
        r_data_o  = RData;
        r_resp_o  = Resp;
        r_last_o  = (rcnt_q == '0);
        if (r_ready_i) begin
          if (rcnt_q == '0) begin
            ar_pop    = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      rcnt_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // ------------------------------------------------------------------ log
`ifdef AXI_ERR_SLV_LOG_EN
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic [AddrWidth-1:0]   err_addr_q, err_addr_d;
  logic [IdWidth-1:0]     err_id_q, err_id_d;
  logic                   err_is_wr_q, err_is_wr_d;
  logic                   err_valid_q, err_valid_d;
  logic [ErrCntWidth:0]   cnt_sum;

  // A clear in the same cycle as a handshake acts first, so that handshake
  // lands in the freshly cleared log.
  always_comb begin
    err_cnt_d   = log_clr_i ? '0 : err_cnt_q;
    err_addr_d  = log_clr_i ? '0 : err_addr_q;
    err_id_d    = log_clr_i ? '0 : err_id_q;
    err_is_wr_d = log_clr_i ? 1'b0 : err_is_wr_q;
    err_valid_d = log_clr_i ? 1'b0 : err_valid_q;
    cnt_sum = {1'b0, err_cnt_d} + (ErrCntWidth + 1)'(aw_hs)
                                + (ErrCntWidth + 1)'(ar_hs);
    err_cnt_d = cnt_sum[ErrCntWidth] ? '1 : cnt_sum[ErrCntWidth-1:0];
    if (!err_valid_d && (aw_hs || ar_hs)) begin
      err_valid_d = 1'b1;
      err_is_wr_d = aw_hs;
      err_addr_d  = aw_hs ? aw_addr_i : ar_addr_i;
      err_id_d    = aw_hs ? aw_id_i : ar_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_id_q    <= '0;
      err_is_wr_q <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      err_id_q    <= err_id_d;
      err_is_wr_q <= err_is_wr_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign err_cnt_o   = err_cnt_q;
  assign err_addr_o  = err_addr_q;
  assign err_id_o    = err_id_q;
  assign err_is_wr_o = err_is_wr_q;
  assign err_valid_o = err_valid_q;
`else
  // Log disabled: the clear input and addresses have no consumer.
  logic unused_log;
  assign unused_log  = ^{log_clr_i, aw_addr_i, ar_addr_i};
  assign err_cnt_o   = '0;
  assign err_addr_o  = '0;
  assign err_id_o    = '0;
  assign err_is_wr_o = 1'b0;
  assign err_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_err_slv_multi.sv
module tb_axi_err_slv_multi;

  localparam logic [63:0] RDATA = 64'hca11ab1ebadcab1e;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        aw_valid_i = 0, w_valid_i = 0, w_last_i = 0, b_ready_i = 1;
  logic        ar_valid_i = 0, r_ready_i = 1, log_clr_i = 0;
  logic [3:0]  aw_id_i = 0, ar_id_i = 0;
  logic [31:0] aw_addr_i = 0, ar_addr_i = 0;
  logic [7:0]  aw_len_i = 0, ar_len_i = 0;
  logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o;
  logic [3:0]  b_id_o, r_id_o, err_id_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic [63:0] r_data_o;
  logic [15:0] err_cnt_o;
  logic [31:0] err_addr_o;
  logic        err_is_wr_o, err_valid_o, len_mismatch_o;

  always #5 clk = ~clk;

  axi_err_slv_multi #(.MaxTrans(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .log_clr_i(log_clr_i), .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o),
    .err_id_o(err_id_o), .err_is_wr_o(err_is_wr_o), .err_valid_o(err_valid_o),
    .len_mismatch_o(len_mismatch_o)
  );

  typedef struct packed {
    logic [3:0] id;
    logic       last;
  } rexp_t;

  rexp_t      r_exp[$];
  logic [3:0] b_exp[$];
  int vecs = 0, errs = 0;
  int cyc = 0, hs_cyc = 0, rise_cyc = 0, last_done_cyc = 0, gap_cyc = 0;
  int r_hs_total = 0, mm_cnt = 0;
  int rr_mode = 0;  // 0: ready, 1: stalled, 2: toggle

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // r_ready driver, settles after the main thread's post-edge drives
  initial forever begin
    @(posedge clk); #2;
    case (rr_mode)
      0: r_ready_i = 1'b1;
      1: r_ready_i = 1'b0;
      default: r_ready_i = ~r_ready_i;
    endcase
  end

  // Monitor: scoreboard pops on handshakes, hold checks during stalls
  logic        r_stall = 0, b_stall = 0, prev_rv = 0;
  logic [3:0]  sv_rid, sv_bid;
  logic [63:0] sv_rdata;
  logic        sv_rlast;
  always @(negedge clk) begin
    if (rst_i) begin
      r_stall = 0; b_stall = 0; prev_rv = 0;
    end else begin
      if (r_stall) begin
        chk("r_hold_valid", r_valid_o, 1);
        chk("r_hold_id", r_id_o, sv_rid);
        chk("r_hold_data", r_data_o, sv_rdata);
        chk("r_hold_last", r_last_o, sv_rlast);
      end
      if (b_stall) begin
        chk("b_hold_valid", b_valid_o, 1);
        chk("b_hold_id", b_id_o, sv_bid);
      end
      if (r_valid_o && !prev_rv) begin
        rise_cyc = cyc;
        gap_cyc  = cyc - last_done_cyc;
      end
      prev_rv = r_valid_o;
      if (r_valid_o && r_ready_i) begin
        r_hs_total++;
        if (r_exp.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          rexp_t e;
          e = r_exp.pop_front();
          chk("r_id", r_id_o, e.id);
          chk("r_data", r_data_o, RDATA);
          chk("r_resp", r_resp_o, 2'b11);
          chk("r_last", r_last_o, e.last);
          if (r_last_o) last_done_cyc = cyc;
        end
      end
      if (b_valid_o && b_ready_i) begin
        if (b_exp.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          chk("b_id", b_id_o, b_exp.pop_front());
          chk("b_resp", b_resp_o, 2'b11);
        end
      end
      r_stall = r_valid_o && !r_ready_i;
      sv_rid = r_id_o; sv_rdata = r_data_o; sv_rlast = r_last_o;
      b_stall = b_valid_o && !b_ready_i;
      sv_bid = b_id_o;
      if (len_mismatch_o) mm_cnt++;
    end
  end

  // which: 0 AR, 1 AW, 2 W. Returns at posedge+1 after the handshake edge.
  task automatic wait_hs(input int which, input string tag);
    int n;
    logic hs;
    n = 0; hs = 0;
    while (!hs && n < 600) begin
      @(negedge clk);
      case (which)
        0: hs = ar_valid_i && ar_ready_o;
        1: hs = aw_valid_i && aw_ready_o;
        default: hs = w_valid_i && w_ready_o;
      endcase
      if (hs) hs_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    if (!hs) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [7:0] len);
    ar_valid_i = 1; ar_id_i = id; ar_len_i = len; ar_addr_i = $urandom;
    for (int b = 0; b <= int'(len); b++) r_exp.push_back('{id, b == int'(len)});
    wait_hs(0, "ar");
    ar_valid_i = 0;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [7:0] len);
    aw_valid_i = 1; aw_id_i = id; aw_len_i = len; aw_addr_i = $urandom;
    b_exp.push_back(id);
    wait_hs(1, "aw");
    aw_valid_i = 0;
  endtask

  task automatic do_w(input logic last);
    w_valid_i = 1; w_last_i = last;
    wait_hs(2, "w");
    w_valid_i = 0; w_last_i = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 2000) begin
      @(posedge clk); n++;
    end
    #1;
    chk({tag, "_r_left"}, r_exp.size(), 0);
    chk({tag, "_b_left"}, b_exp.size(), 0);
  endtask

  task automatic chk_log(input string tag, input logic [15:0] cnt, input logic [31:0] addr,
                         input logic [3:0] id, input logic wr, input logic v);
    @(negedge clk);
`ifdef AXI_ERR_SLV_LOG_EN
    chk({tag, "_cnt"}, err_cnt_o, cnt);
    chk({tag, "_addr"}, err_addr_o, addr);
    chk({tag, "_id"}, err_id_o, id);
    chk({tag, "_is_wr"}, err_is_wr_o, wr);
    chk({tag, "_valid"}, err_valid_o, v);
`else
    chk({tag, "_off"}, {err_cnt_o, err_addr_o, err_id_o, err_is_wr_o, err_valid_o},
        {cnt & 16'h0, addr & 32'h0, id & 4'h0, wr & 1'b0, v & 1'b0});
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int base, mm0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    // reset state
    @(negedge clk);
    chk("rst_aw_ready", aw_ready_o, 1);
    chk("rst_ar_ready", ar_ready_o, 1);
    chk("rst_outs", {w_ready_o, b_valid_o, r_valid_o, r_last_o, len_mismatch_o, b_id_o,
                     b_resp_o, r_id_o, r_resp_o}, 0);
    chk("rst_rdata", r_data_o, 0);
    chk("rst_log", {err_cnt_o, err_addr_o, err_id_o, err_is_wr_o, err_valid_o}, 0);
    @(posedge clk); #1;

    // single burst: latency n+2
    do_ar(4'd3, 8'd3);
    base = hs_cyc;
    drain("burst4");
    chk("ar_latency", rise_cyc - base, 2);

    // back-to-back bursts, len=0 first: one idle cycle between
    do_ar(4'd1, 8'd0);
    do_ar(4'd2, 8'd2);
    drain("b2b");
    chk("burst_gap", gap_cyc, 2);

    // len=255: 256 beats
    base = r_hs_total;
    do_ar(4'd6, 8'd255);
    drain("len255");
    chk("len255_beats", r_hs_total - base, 256);

    // r_ready toggling mid-burst
    rr_mode = 2;
    base = r_hs_total;
    do_ar(4'd9, 8'd5);
    drain("toggle");
    chk("toggle_beats", r_hs_total - base, 6);

    // queue full with r_ready held low (depth 2)
    rr_mode = 1;
    @(posedge clk); #1;
    do_ar(4'd1, 8'd1);
    do_ar(4'd2, 8'd1);
    ar_valid_i = 1; ar_id_i = 4'd3; ar_len_i = 0;
    r_exp.push_back('{4'd3, 1'b1});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ar_full_ready", ar_ready_o, 0);
    @(posedge clk); #1;
    rr_mode = 0;
    base = r_hs_total;
    wait_hs(0, "ar3");
    ar_valid_i = 0;
    chk("ar_reassert_beats", r_hs_total - base, 2);
    drain("full");

    // writes: matching length, then short burst
    mm0 = mm_cnt;
    do_aw(4'd5, 8'd1);
    do_w(0);
    do_w(1);
    repeat (3) @(posedge clk); #1;
    chk("mm_none", mm_cnt - mm0, 0);
    do_aw(4'd6, 8'd1);
    do_w(1);
    repeat (3) @(posedge clk); #1;
    chk("mm_pulse", mm_cnt - mm0, 1);
    drain("wr");

    // B held while b_ready low
    b_ready_i = 0;
    do_aw(4'd4, 8'd0);
    do_w(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b_stall_valid", b_valid_o, 1);
    @(posedge clk); #1;
    b_ready_i = 1;
    drain("bstall");

    // reset during beat 2 of a len=7 read
    base = r_hs_total;
    do_ar(4'd7, 8'd7);
    begin
      int n;
      n = 0;
      while (r_hs_total - base < 1 && n < 100) begin @(posedge clk); #1; n++; end
    end
    rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
    r_exp.delete();
    chk("rstmid_rvalid", r_valid_o, 0);
    chk("rstmid_ready", {aw_ready_o, ar_ready_o, w_ready_o, b_valid_o}, 4'b1100);
    base = r_hs_total;
    repeat (10) @(posedge clk); #1;
    chk("rstmid_nobeats", r_hs_total - base, 0);

    // log: simultaneous AW/AR, AW wins
    aw_valid_i = 1; aw_id_i = 4'd2; aw_addr_i = 32'h1000; aw_len_i = 0;
    ar_valid_i = 1; ar_id_i = 4'd8; ar_addr_i = 32'h2000; ar_len_i = 0;
    r_exp.push_back('{4'd8, 1'b1});
    b_exp.push_back(4'd2);
    @(negedge clk);
    chk("log_both_ready", {aw_ready_o, ar_ready_o}, 2'b11);
    @(posedge clk); #1;
    aw_valid_i = 0; ar_valid_i = 0;
    do_w(1);
    chk_log("log_tie", 16'd2, 32'h1000, 4'd2, 1'b1, 1'b1);
    log_clr_i = 1;
    @(posedge clk); #1;
    log_clr_i = 0;
    chk_log("log_clr", 16'd0, 32'h0, 4'd0, 1'b0, 1'b0);
    do_ar(4'd0, 8'd0);
    chk_log("log_ar", 16'd1, ar_addr_i, 4'd0, 1'b0, 1'b1);
    log_clr_i = 1;
    ar_valid_i = 1; ar_id_i = 4'hA; ar_addr_i = 32'h3000; ar_len_i = 0;
    r_exp.push_back('{4'hA, 1'b1});
    wait_hs(0, "ar_clr");
    log_clr_i = 0; ar_valid_i = 0;
    chk_log("log_clr_hs", 16'd1, 32'h3000, 4'hA, 1'b0, 1'b1);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
